// File: rtl/accum_writeback.sv
// Drains a latched accumulator snapshot into BRAM, one write per eligible entry,
// under a valid/ready handshake. The accumulator is released right after capture.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SCAN  | walking entries in index order, writing eligible ones
// DONE  | one-cycle done pulse, then back to IDLE
module accum_writeback #(
  parameter int data_locations    = 1360,
  parameter int data_width        = 17,
  parameter int address_width     = 27,
  parameter int stored_data_width = 44,
  parameter bit skip_zero         = 1'b1,
  parameter int index_width       = 11
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [data_locations*stored_data_width-1:0] snapshot_in,
  input  logic [data_locations-1:0]                   entry_mask,
  output logic                                        bram_we,
  output logic [address_width-1:0]                    bram_addr,
  output logic [data_width-1:0]                       bram_wdata,
  input  logic                                        bram_ready,
  output logic                                        accumulator_reset,
  output logic                                        busy,
  output logic                                        done,
  output logic [index_width-1:0]                      write_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                         state;
  logic [index_width-1:0]         idx;
  logic [stored_data_width-1:0]   shadow [data_locations];
  logic [data_locations-1:0]      mask;

  logic [stored_data_width-1:0]   entry;
  logic [data_width-1:0]          entry_data;
  logic [address_width-1:0]       entry_addr;
  logic                           eligible;
  logic                           last;

  assign entry      = shadow[idx];
  assign entry_data = entry[stored_data_width-1 -: data_width];
  assign entry_addr = entry[address_width-1:0];
  assign eligible   = mask[idx] && !(skip_zero && (entry_data == '0));
  assign last       = (idx == index_width'(data_locations - 1));

  // Write port depends only on registered state and shadow, never on bram_ready.
  assign bram_we    = (state == SCAN) && eligible;
  assign bram_addr  = (state == SCAN) ? entry_addr : '0;
  assign bram_wdata = (state == SCAN) ? entry_data : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      mask              <= '0;
      write_count       <= '0;
      accumulator_reset <= 1'b0;
      done              <= 1'b0;
      for (int i = 0; i < data_locations; i++) shadow[i] <= '0;
    end else begin
      accumulator_reset <= 1'b0;
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < data_locations; i++)
              shadow[i] <= snapshot_in[i*stored_data_width +: stored_data_width];
            mask              <= entry_mask;
            idx               <= '0;
            write_count       <= '0;
            accumulator_reset <= 1'b1;
            state             <= SCAN;
          end
        end
        SCAN: begin
          if (!eligible || bram_ready) begin
            if (eligible) write_count <= write_count + 1'b1;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_writeback.sv
// Bench for accum_writeback: two instances (skip_zero on/off) share stimulus;
// a negedge monitor pops expected writes from per-instance scoreboards.
module tb_accum_writeback;
  localparam int DL = 4;
  localparam int DW = 17;
  localparam int AW = 27;
  localparam int SW = 44;
  localparam int IW = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic bram_ready = 1'b1;
  logic [DL*SW-1:0] snapshot_in = '0;
  logic [DL-1:0]    entry_mask = '0;

  logic s_we, s_ar, s_busy, s_done, n_we, n_ar, n_busy, n_done;
  logic [AW-1:0] s_addr, n_addr;
  logic [DW-1:0] s_wdata, n_wdata;
  logic [IW-1:0] s_wc, n_wc;

  int tests = 0;
  int fails = 0;
  int edges = 0;
  int t0 = 0;
  wr_t q_s[$];
  wr_t q_n[$];

  accum_writeback #(.data_locations(DL), .data_width(DW), .address_width(AW),
    .stored_data_width(SW), .skip_zero(1'b1), .index_width(IW)) u_skip (
    .clock(clock), .reset(reset), .start(start), .snapshot_in(snapshot_in),
    .entry_mask(entry_mask), .bram_we(s_we), .bram_addr(s_addr), .bram_wdata(s_wdata),
    .bram_ready(bram_ready), .accumulator_reset(s_ar), .busy(s_busy), .done(s_done),
    .write_count(s_wc));

  accum_writeback #(.data_locations(DL), .data_width(DW), .address_width(AW),
    .stored_data_width(SW), .skip_zero(1'b0), .index_width(IW)) u_noskip (
    .clock(clock), .reset(reset), .start(start), .snapshot_in(snapshot_in),
    .entry_mask(entry_mask), .bram_we(n_we), .bram_addr(n_addr), .bram_wdata(n_wdata),
    .bram_ready(bram_ready), .accumulator_reset(n_ar), .busy(n_busy), .done(n_done),
    .write_count(n_wc));

  always #5 clock = ~clock;
  always @(posedge clock) edges <= edges + 1;

  // Cycle 1 is the cycle right after the start edge.
  always @(negedge clock) begin
    wr_t e;
    if (!reset) begin
      if (s_we && bram_ready) begin
        tests++;
        if (q_s.size() == 0) begin
          fails++;
          $display("FAIL wr_skip: unexpected write addr=%0d data=%0d cycle=%0d", s_addr, s_wdata, edges - t0 + 1);
        end else begin
          e = q_s.pop_front();
          if (s_addr !== e.addr || s_wdata !== e.data || (edges - t0 + 1) !== e.cyc) begin
            fails++;
            $display("FAIL wr_skip: got addr=%0d data=%0d cycle=%0d, expected addr=%0d data=%0d cycle=%0d",
                     s_addr, s_wdata, edges - t0 + 1, e.addr, e.data, e.cyc);
          end
        end
      end
      if (n_we && bram_ready) begin
        tests++;
        if (q_n.size() == 0) begin
          fails++;
          $display("FAIL wr_noskip: unexpected write addr=%0d data=%0d cycle=%0d", n_addr, n_wdata, edges - t0 + 1);
        end else begin
          e = q_n.pop_front();
          if (n_addr !== e.addr || n_wdata !== e.data || (edges - t0 + 1) !== e.cyc) begin
            fails++;
            $display("FAIL wr_noskip: got addr=%0d data=%0d cycle=%0d, expected addr=%0d data=%0d cycle=%0d",
                     n_addr, n_wdata, edges - t0 + 1, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  function automatic logic [DL*SW-1:0] build_snap(input int dbase, input int abase, input int zero_idx);
    logic [DL*SW-1:0] s;
    s = '0;
    for (int i = 0; i < DL; i++)
      s[i*SW +: SW] = {DW'((i == zero_idx) ? 0 : dbase + i), AW'(abase + i)};
    return s;
  endfunction

  // Reference model: writes in index order, one per cycle, delayed by stalls.
  task automatic push_exp(input logic [DL-1:0] m, input int dbase, input int abase,
                          input int zero_idx, input bit skip, input int stall_entry, input int stall_len);
    wr_t w;
    int d;
    for (int i = 0; i < DL; i++) begin
      d = (i == zero_idx) ? 0 : dbase + i;
      if (m[i] && !(skip && d == 0)) begin
        w.addr = AW'(abase + i);
        w.data = DW'(d);
        w.cyc  = i + 1 + ((i >= stall_entry) ? stall_len : 0);
        if (skip) q_s.push_back(w);
        else      q_n.push_back(w);
      end
    end
  endtask

  task automatic launch(input logic [DL-1:0] m, input int dbase, input int abase, input int zero_idx);
    snapshot_in = build_snap(dbase, abase, zero_idx);
    entry_mask  = m;
    start       = 1'b1;
    @(posedge clock); #1;
    t0    = edges;
    start = 1'b0;
  endtask

  // Runs until done (bounded), optionally re-pulsing start mid-drain; ends in first IDLE cycle.
  task automatic wait_done(input int restart_at, output int dcyc, output int ar_cnt, output int ar_cyc);
    dcyc = -1; ar_cnt = 0; ar_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == restart_at) begin
        start       = 1'b1;
        snapshot_in = build_snap(50, 200, -1);
        entry_mask  = 4'b0011;
      end
      if (k == restart_at + 2) start = 1'b0;
      #1;
      if (s_ar) begin ar_cnt++; ar_cyc = k; end
      if (s_done) begin dcyc = k; break; end
      @(posedge clock); #1;
    end
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (s_we !== 1'b0 || s_addr !== '0 || s_wdata !== '0 || s_ar !== 1'b0 ||
        s_busy !== 1'b0 || s_done !== 1'b0 || s_wc !== '0) begin
      fails++;
      $display("FAIL reset_vals: we=%b addr=%0d wdata=%0d ar=%b busy=%b done=%b wc=%0d, expected all 0",
               s_we, s_addr, s_wdata, s_ar, s_busy, s_done, s_wc);
    end
    tests++;
    if (n_we !== 1'b0 || n_wc !== '0 || n_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_noskip: we=%b wc=%0d busy=%b, expected 0", n_we, n_wc, n_busy);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_end(input string name, input int dc, input int dc_exp, input int s_exp, input int n_exp);
    tests++;
    if (dc !== dc_exp) begin fails++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, dc, dc_exp); end
    tests++;
    if (s_wc !== IW'(s_exp) || n_wc !== IW'(n_exp)) begin
      fails++;
      $display("FAIL %s_write_count: got skip=%0d noskip=%0d expected %0d/%0d", name, s_wc, n_wc, s_exp, n_exp);
    end
    tests++;
    if (q_s.size() !== 0 || q_n.size() !== 0) begin
      fails++;
      $display("FAIL %s_missing_writes: %0d/%0d left, expected 0", name, q_s.size(), q_n.size());
      q_s.delete(); q_n.delete();
    end
  endtask

  task automatic test_full;
    int dc, ar, arc;
    push_exp(4'b1111, 1, 100, -1, 1'b1, 99, 0);
    push_exp(4'b1111, 1, 100, -1, 1'b0, 99, 0);
    launch(4'b1111, 1, 100, -1);
    wait_done(-10, dc, ar, arc);
    tests++;
    if (ar !== 1 || arc !== 1) begin
      fails++;
      $display("FAIL full_acc_reset: count=%0d last_cycle=%0d, expected 1 at cycle 1", ar, arc);
    end
    tests++;
    if (s_busy !== 1'b0) begin fails++; $display("FAIL full_busy_idle: got %b expected 0", s_busy); end
    check_end("full", dc, 5, 4, 4);
  endtask

  task automatic test_mask;
    int dc, ar, arc;
    push_exp(4'b0101, 1, 100, -1, 1'b1, 99, 0);
    push_exp(4'b0101, 1, 100, -1, 1'b0, 99, 0);
    launch(4'b0101, 1, 100, -1);
    wait_done(-10, dc, ar, arc);
    check_end("mask", dc, 5, 2, 2);
  endtask

  task automatic test_skip_zero;
    int dc, ar, arc;
    push_exp(4'b1111, 1, 100, 2, 1'b1, 99, 0);
    push_exp(4'b1111, 1, 100, 2, 1'b0, 99, 0);
    launch(4'b1111, 1, 100, 2);
    wait_done(-10, dc, ar, arc);
    check_end("skip_zero", dc, 5, 3, 4);
  endtask

  task automatic test_stall;
    int dc;
    push_exp(4'b1111, 1, 100, -1, 1'b1, 1, 3);
    push_exp(4'b1111, 1, 100, -1, 1'b0, 1, 3);
    launch(4'b1111, 1, 100, -1);
    dc = -1;
    for (int k = 1; k <= 30; k++) begin
      bram_ready = !(k >= 2 && k <= 4);
      #1;
      if (k >= 2 && k <= 5) begin
        tests++;
        if (s_we !== 1'b1 || s_addr !== AW'(101) || s_wdata !== DW'(2)) begin
          fails++;
          $display("FAIL stall_hold: cycle %0d we=%b addr=%0d data=%0d, expected 1/101/2", k, s_we, s_addr, s_wdata);
        end
      end
      if (s_done) begin dc = k; break; end
      @(posedge clock); #1;
    end
    bram_ready = 1'b1;
    @(posedge clock); #1;
    check_end("stall", dc, 8, 4, 4);
  endtask

  task automatic test_back_to_back;
    int dc, ar, arc;
    push_exp(4'b1111, 1, 100, -1, 1'b1, 99, 0);
    push_exp(4'b1111, 1, 100, -1, 1'b0, 99, 0);
    launch(4'b1111, 1, 100, -1);
    wait_done(2, dc, ar, arc);
    tests++;
    if (ar !== 1) begin fails++; $display("FAIL restart_acc_reset: count=%0d expected 1", ar); end
    check_end("restart_ignored", dc, 5, 4, 4);
    push_exp(4'b1111, 50, 200, -1, 1'b1, 99, 0);
    push_exp(4'b1111, 50, 200, -1, 1'b0, 99, 0);
    launch(4'b1111, 50, 200, -1);
    wait_done(-10, dc, ar, arc);
    tests++;
    if (ar !== 1 || arc !== 1) begin
      fails++;
      $display("FAIL b2b_acc_reset: count=%0d cycle=%0d expected 1 at 1", ar, arc);
    end
    check_end("back_to_back", dc, 5, 4, 4);
  endtask

  task automatic test_async_reset;
    wr_t w;
    int bad;
    w.addr = AW'(100); w.data = DW'(1); w.cyc = 1;
    q_s.push_back(w);
    q_n.push_back(w);
    launch(4'b1111, 1, 100, -1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    tests++;
    if (s_we !== 1'b0 || s_busy !== 1'b0 || s_wc !== '0 || n_we !== 1'b0 || n_wc !== '0) begin
      fails++;
      $display("FAIL async_reset: we=%b busy=%b wc=%0d noskip_we=%b noskip_wc=%0d, expected all 0",
               s_we, s_busy, s_wc, n_we, n_wc);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (s_we || n_we || s_done || s_busy) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL post_reset_activity: %0d active cycles, expected 0", bad); end
    tests++;
    if (q_s.size() !== 0 || q_n.size() !== 0) begin
      fails++;
      $display("FAIL async_missing_writes: %0d/%0d left, expected 0", q_s.size(), q_n.size());
      q_s.delete(); q_n.delete();
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_mask();
    test_skip_zero();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accum_writeback.md
# accum_writeback

Drains a captured accumulator snapshot into BRAM one entry per accepted write. It sits between the accumulator's packed data_out bus and the BRAM write port, and is the write-side counterpart to the accumulator's load path. On start it latches the full snapshot and an entry mask, then pulses accumulator_reset so the accumulator can restart immediately. It then walks every location in index order and issues a data/address write for each eligible entry under a valid/ready handshake.

## Interface
- data_locations, 1360, number of entries in the snapshot
- data_width, 17, data field width per entry
- address_width, 27, address field width per entry
- stored_data_width, 44, entry width; data occupies bits [43:27], address bits [26:0]
- skip_zero, 1, when 1, entries whose data field is zero are not written
- index_width, 11, width of the entry index and write counter; must satisfy 2^index_width > data_locations
- clock  in  1  system clock, rising edge
- reset  in  1  reset; one clock, asynchronous, active-high
- start  in  1  request a drain; sampled only in IDLE
- snapshot_in  in  data_locations*stored_data_width  packed accumulator contents; entry i is at [stored_data_width*i +: stored_data_width]
- entry_mask  in  data_locations  1 = entry may be written
- bram_we  out  1  write valid
- bram_addr  out  address_width  write address, taken from the entry's address field
- bram_wdata  out  data_width  write data, taken from the entry's data field
- bram_ready  in  1  BRAM accepts the write when bram_we && bram_ready
- accumulator_reset  out  1  one-cycle pulse to clear the accumulator
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse at the end of a drain
- write_count  out  index_width  writes accepted in the current or last drain

## Operation
- States: IDLE, SCAN, DONE. All state, index, shadow and counter registers are cleared by reset.
- IDLE, start=1:
  - Latch snapshot_in into the shadow register and entry_mask into the mask register.
  - Clear idx and write_count.
  - Assert accumulator_reset for the next cycle only.
  - Go to SCAN.
- Eligible(idx) = mask[idx] && !(skip_zero && shadow data[idx] == 0).
- SCAN, per cycle:
  - bram_we = eligible(idx). bram_addr and bram_wdata come from shadow[idx].
  - If eligible and bram_ready: write accepted, write_count++, advance.
  - If eligible and !bram_ready: hold idx. bram_we, bram_addr and bram_wdata stay stable until accepted.
  - If not eligible: advance, with bram_we=0.
  - Advance means: idx++, or go to DONE if idx == data_locations-1.
- DONE: done=1 for one cycle, then go to IDLE. write_count holds its value until the next start.
- start outside IDLE is ignored. Snapshot and mask inputs are don't-care except on the start cycle.
- No arithmetic wrap: write_count ≤ data_locations by construction.

## Timing
- Reset values: bram_we=0, bram_addr=0, bram_wdata=0, accumulator_reset=0, busy=0, done=0, write_count=0, state=IDLE.
- Reset asserted mid-drain aborts immediately, with no further writes. Shadow contents are cleared.
- Output registers:
  - accumulator_reset and done are registered.
  - bram_* are combinational from registered state and shadow only. There is no path from bram_ready to bram_addr or bram_wdata.
- Drain duration:
  - start is sampled at edge 0; SCAN covers cycles 1..data_locations (+ stall cycles); done is high in the following cycle.
  - With bram_ready tied high, the drain takes exactly data_locations+1 cycles after the start edge, independent of how many entries are eligible.
- Overlap with accumulator:
  - accumulator_reset is high in cycle 1, which is also the first SCAN cycle.
  - The shadow register is already latched, so the accumulator may be refilled at once.
- busy rises in cycle 1 and falls after the DONE cycle. A start in the cycle busy falls is accepted.

## Test plan
- data_locations=4, mask=4'b1111, all data nonzero, entries i = {data=i+1, addr=100+i}, ready=1 -> four writes to addrs 100..103 with data 1..4 in cycles 1..4, done in cycle 5, write_count=4, accumulator_reset high only in cycle 1.
- Same snapshot, mask=4'b0101 -> writes only to addr 100 and 102, done still in cycle 5, write_count=2.
- skip_zero=1, entry 2 data=0, mask=4'b1111 -> entry 2 is skipped, write_count=3. With skip_zero=0 -> 4 writes, including data 0 to addr 102.
- bram_ready low for 3 cycles on entry 1 -> bram_we, addr 101 and data 2 stay stable for 4 cycles, exactly one write is accepted, done is delayed by 3 cycles.
- start pulsed again during SCAN -> ignored: no re-latch, no second accumulator_reset. Back-to-back start in the first IDLE cycle after done -> new drain begins.
- Async reset asserted mid-SCAN between clock edges -> bram_we=0, busy=0 and write_count=0 immediately. No write occurs after reset is released until a new start.
